// File: rtl/esc_pkg.sv
// Shared types and default constants for the ESC supervisory logic.
package esc_pkg;

    localparam int ESC_DW = 16;

    localparam logic [ESC_DW-1:0] ESC_START_PERIOD = 16'hC000;
    localparam logic [ESC_DW-1:0] ESC_MIN_PERIOD   = 16'd400;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ALIGN = 3'd1,
        ST_RAMP  = 3'd2,
        ST_RUN   = 3'd3,
        ST_STOP  = 3'd4,
        ST_FAULT = 3'd5
    } esc_state_e;

    // External PID gain triple, packed in {Kp,Ki,Kd} order to match the gain buses.
    typedef struct packed {
        logic [ESC_DW-1:0] kp;
        logic [ESC_DW-1:0] ki;
        logic [ESC_DW-1:0] kd;
    } esc_gains_t;

endpackage

// File: rtl/esc_slew_limiter.sv
// Rate-limited stepper: moves ref toward goal by at most step_size once per
// RAMP_INTERVAL cycles while run_i is high; load_i parks ref at load_val_i.
module esc_slew_limiter #(
    parameter int DW            = 16,
    parameter int RAMP_INTERVAL = 1000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_i,
    input  logic [DW-1:0] load_val_i,
    input  logic          run_i,
    input  logic [DW-1:0] goal_i,
    input  logic [DW-1:0] step_size_i,
    output logic [DW-1:0] ref_o,
    output logic [DW-1:0] ref_next_o
);

    localparam logic [DW-1:0] CNT_LAST = DW'(RAMP_INTERVAL - 1);

    logic [DW-1:0] ref_q, ref_d, cnt_q, cnt_d;
    logic [DW:0]   ref_x, goal_x, stp_x, diff_x, amt_x, stepped_x;
    logic          stepped_unused;

    // One extra bit of headroom so the step can never wrap ref.
    always_comb begin
        ref_x     = {1'b0, ref_q};
        goal_x    = {1'b0, goal_i};
        stp_x     = (step_size_i == '0) ? (DW+1)'(1) : {1'b0, step_size_i};
        diff_x    = (ref_x > goal_x) ? (ref_x - goal_x) : (goal_x - ref_x);
        amt_x     = (stp_x < diff_x) ? stp_x : diff_x;
        stepped_x = (ref_x > goal_x) ? (ref_x - amt_x) : (ref_x + amt_x);

        ref_d = ref_q;
        cnt_d = '0;
        if (load_i) begin
            ref_d = load_val_i;
        end else if (run_i) begin
            if (cnt_q == CNT_LAST) ref_d = stepped_x[DW-1:0];
            else                   cnt_d = cnt_q + 1'b1;
        end
    end

    assign stepped_unused = stepped_x[DW];
    assign ref_o          = ref_q;
    assign ref_next_o     = ref_d;

    // Reference and interval counter registers; counter idles at 0 when not running.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ref_q <= '0;
            cnt_q <= '0;
        end else begin
            ref_q <= ref_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/esc_ramp_sequencer.sv
// BLDC ESC supervisor: arm/disarm, align-then-ramp soft start, bounded-rate
// period slewing, gain scheduling and stall fault latch. All outputs registered.
module esc_ramp_sequencer
    import esc_pkg::*;
#(
    parameter int                    DATA_WIDTH    = ESC_DW,
    parameter logic [DATA_WIDTH-1:0] START_PERIOD  = ESC_START_PERIOD,
    parameter logic [DATA_WIDTH-1:0] MIN_PERIOD    = ESC_MIN_PERIOD,
    parameter int                    ALIGN_CYCLES  = 50000,
    parameter int                    RAMP_INTERVAL = 1000,
    parameter logic [23:0]           STALL_CYCLES  = 24'd2000000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    arm,
    input  logic                    fault_clear,
    input  logic                    target_valid,
    output logic                    target_ready,
    input  logic [DATA_WIDTH-1:0]   target_period,
    input  logic [DATA_WIDTH-1:0]   step_size,
    input  logic [3*DATA_WIDTH-1:0] gains_ramp,
    input  logic [3*DATA_WIDTH-1:0] gains_run,
    input  logic                    enc_edge,
    output logic                    pwm_en,
    output logic [DATA_WIDTH-1:0]   period_reference,
    output logic                    override_internal_pid,
    output logic [DATA_WIDTH-1:0]   Kp_ext,
    output logic [DATA_WIDTH-1:0]   Ki_ext,
    output logic [DATA_WIDTH-1:0]   Kd_ext,
    output logic [2:0]              state,
    output logic                    fault
);

    localparam logic [DATA_WIDTH-1:0] ALIGN_LAST = DATA_WIDTH'(ALIGN_CYCLES - 1);
    localparam logic [23:0]           STALL_LAST = STALL_CYCLES - 24'd1;

    esc_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0] tgt_q, tgt_d, tgt_clamped, align_q, align_d;
    logic [23:0]           stall_q, stall_d;
    logic                  in_motion, stall_hit, accept;
    logic                  slew_load, slew_run;
    logic [DATA_WIDTH-1:0] slew_goal, slew_ref, slew_next;

    logic                  pwm_en_q, pwm_en_d, override_q, override_d;
    logic                  fault_q, fault_d, ready_q, ready_d;
    logic [DATA_WIDTH-1:0] period_ref_q, period_ref_d;
    esc_gains_t            gains_q, gains_d;

    // Handshake, stall detect and slew control. The step always aims at the
    // target held at the start of the cycle; a same-cycle new target only
    // changes where the FSM decides the ramp has finished.
    always_comb begin
        in_motion   = (state_q == ST_RAMP) || (state_q == ST_RUN) || (state_q == ST_STOP);
        stall_hit   = in_motion && !enc_edge && (stall_q == STALL_LAST);
        accept      = target_valid && ready_q;
        tgt_clamped = (target_period < MIN_PERIOD)   ? MIN_PERIOD   :
                      (target_period > START_PERIOD) ? START_PERIOD : target_period;
        tgt_d       = accept ? tgt_clamped : tgt_q;
        slew_load   = !in_motion;
        slew_run    = !stall_hit && (((state_q == ST_RAMP) && arm) ||
                                     ((state_q == ST_STOP) && !arm));
        slew_goal   = (state_q == ST_STOP) ? START_PERIOD : tgt_q;
    end

    esc_slew_limiter #(
        .DW            (DATA_WIDTH),
        .RAMP_INTERVAL (RAMP_INTERVAL)
    ) u_slew (
        .clk         (clk),
        .reset       (reset),
        .load_i      (slew_load),
        .load_val_i  (START_PERIOD),
        .run_i       (slew_run),
        .goal_i      (slew_goal),
        .step_size_i (step_size),
        .ref_o       (slew_ref),
        .ref_next_o  (slew_next)
    );

    // Next-state logic: stall > disarm > target update > ramp completion.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (arm) state_d = ST_ALIGN;
            ST_ALIGN: begin
                if (!arm)                       state_d = ST_IDLE;
                else if (align_q == ALIGN_LAST) state_d = ST_RAMP;
            end
            ST_RAMP: begin
                if (stall_hit)               state_d = ST_FAULT;
                else if (!arm)               state_d = ST_STOP;
                else if (slew_next == tgt_d) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (stall_hit)              state_d = ST_FAULT;
                else if (!arm)              state_d = ST_STOP;
                else if (slew_ref != tgt_d) state_d = ST_RAMP;
            end
            ST_STOP: begin
                if (stall_hit)                      state_d = ST_FAULT;
                else if (arm)                       state_d = ST_RAMP;
                else if (slew_next == START_PERIOD) state_d = ST_IDLE;
            end
            ST_FAULT: if (fault_clear && !arm) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Dwell/stall counters and output values derived from the next state.
    always_comb begin
        align_d = ((state_q == ST_ALIGN) && (state_d == ST_ALIGN)) ? align_q + 1'b1 : '0;
        if ((state_d != state_q) || enc_edge ||
            !((state_d == ST_RAMP) || (state_d == ST_RUN) || (state_d == ST_STOP)))
            stall_d = '0;
        else
            stall_d = stall_q + 24'd1;

        pwm_en_d     = 1'b0;
        override_d   = 1'b0;
        period_ref_d = '0;
        gains_d      = '0;
        fault_d      = 1'b0;
        ready_d      = 1'b1;
        case (state_d)
            ST_ALIGN: begin
                pwm_en_d     = 1'b1;
                override_d   = 1'b1;
                period_ref_d = START_PERIOD;
                gains_d      = esc_gains_t'(gains_ramp);
            end
            ST_RAMP, ST_STOP: begin
                pwm_en_d     = 1'b1;
                override_d   = 1'b1;
                period_ref_d = slew_next;
                gains_d      = esc_gains_t'(gains_ramp);
            end
            ST_RUN: begin
                pwm_en_d     = 1'b1;
                override_d   = 1'b1;
                period_ref_d = slew_next;
                gains_d      = esc_gains_t'(gains_run);
            end
            ST_FAULT: begin
                fault_d = 1'b1;
                ready_d = 1'b0;
            end
            default: ;
        endcase
    end

    // State, target, counters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            tgt_q        <= START_PERIOD;
            align_q      <= '0;
            stall_q      <= '0;
            pwm_en_q     <= 1'b0;
            override_q   <= 1'b0;
            period_ref_q <= '0;
            gains_q      <= '0;
            fault_q      <= 1'b0;
            ready_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            tgt_q        <= tgt_d;
            align_q      <= align_d;
            stall_q      <= stall_d;
            pwm_en_q     <= pwm_en_d;
            override_q   <= override_d;
            period_ref_q <= period_ref_d;
            gains_q      <= gains_d;
            fault_q      <= fault_d;
            ready_q      <= ready_d;
        end
    end

    assign state                 = state_q;
    assign target_ready          = ready_q;
    assign pwm_en                = pwm_en_q;
    assign override_internal_pid = override_q;
    assign period_reference      = period_ref_q;
    assign Kp_ext                = gains_q.kp;
    assign Ki_ext                = gains_q.ki;
    assign Kd_ext                = gains_q.kd;
    assign fault                 = fault_q;

endmodule
